// File: rtl/intc_ctrl.sv
// Four-source fixed-priority interrupt controller (source 0 highest) with ack/EOI handshake.
// Define INTC_NESTING_EN to allow higher-priority requests to preempt an in-service one.
module intc_ctrl #(
  parameter logic [3:0] RESET_MASK = 4'b0000,
  parameter bit         EDGE_MODE  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] irq_in,
  input  logic       mask_we,
  input  logic [3:0] mask_wdata,
  input  logic       irq_ack,
  input  logic       eoi,
  output logic       irq,
  output logic [1:0] irq_id,
  output logic [3:0] pending,
  output logic [3:0] in_service,
  output logic [3:0] mask
);

  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

  state_t     state;
  logic [3:0] irq_in_q;
  logic [3:0] cap;
  logic [3:0] hit;
  logic [3:0] isr_eoi;
  logic [3:0] id_bit;
  logic [1:0] cand;
  logic       cand_ok;
  logic       eligible;
`ifdef INTC_NESTING_EN
  logic [1:0] isr_low;
  logic       isr_found;
`endif

  always_comb begin
    cap     = EDGE_MODE ? (irq_in & ~irq_in_q) : irq_in;
    hit     = pending & mask;
    id_bit  = 4'b0001 << irq_id;
    // Clearing the lowest set bit is the highest-priority in-service source.
    isr_eoi = in_service & (in_service - 4'd1);
    cand    = '0;
    cand_ok = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (hit[i] && !cand_ok) begin
        cand    = 2'(i);
        cand_ok = 1'b1;
      end
    end
`ifdef INTC_NESTING_EN
    isr_low   = '0;
    isr_found = 1'b0;
    for (int unsigned i = 0; i < 4; i++) begin
      if (in_service[i] && !isr_found) begin
        isr_low   = 2'(i);
        isr_found = 1'b1;
      end
    end
    eligible = cand_ok && (!isr_found || (cand < isr_low));
`else
    eligible = cand_ok && (in_service == '0);
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      irq        <= 1'b0;
      irq_id     <= '0;
      pending    <= '0;
      in_service <= '0;
      mask       <= RESET_MASK;
      irq_in_q   <= '0;
    end else begin
      irq_in_q <= irq_in;
      pending  <= pending | cap;
      if (mask_we) mask <= mask_wdata;
      case (state)
        IDLE: begin
          if (eligible) begin
            irq_id <= cand;
            irq    <= 1'b1;
            state  <= REQ;
          end
        end
        REQ: begin
          if (irq_ack) begin
            // A new capture in the ack cycle overrides the clear.
            pending    <= (pending & ~id_bit) | cap;
            in_service <= in_service | id_bit;
            irq        <= 1'b0;
            state      <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            in_service <= isr_eoi;
            if (isr_eoi == '0) state <= IDLE;
          end
`ifdef INTC_NESTING_EN
          else if (eligible) begin
            irq_id <= cand;
            irq    <= 1'b1;
            state  <= REQ;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
